// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment scan driver with shadow register and leading-zero blanking.
// Optional hex glyphs for values 10-15 are enabled by defining SSD_HEX_EN.
module ssd_scan_driver #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic                  load,
  input  logic                  lz_en,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   an
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] COUNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_DIGITS - 1);
  localparam logic [6:0]    SEG_BLANK = 7'b1111111;

  logic [CW-1:0]         count;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         next_idx;
  logic [4*N_DIGITS-1:0] shadow;
  logic                  tick;
  logic [3:0]            sel_nibble;
  logic [N_DIGITS-1:0]   sel_an;
  logic                  sel_blank;
  logic                  all_zero;

  function automatic logic [6:0] decode(input logic [3:0] value);
    case (value)
      4'd0:    decode = 7'b0000001;
      4'd1:    decode = 7'b1001111;
      4'd2:    decode = 7'b0010010;
      4'd3:    decode = 7'b0000110;
      4'd4:    decode = 7'b1001100;
      4'd5:    decode = 7'b0100100;
      4'd6:    decode = 7'b0100000;
      4'd7:    decode = 7'b0001111;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0000100;
`ifdef SSD_HEX_EN
      4'd10:   decode = 7'b0001000;
      4'd11:   decode = 7'b1100000;
      4'd12:   decode = 7'b0110001;
      4'd13:   decode = 7'b1000010;
      4'd14:   decode = 7'b0110000;
      default: decode = 7'b0111000;
`else
      default: decode = SEG_BLANK;
`endif
    endcase
  endfunction

  assign tick = (count == COUNT_MAX);

  // Walk digits from the top down so all_zero means "this digit and every higher one is 0".
  always_comb begin
    next_idx   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    sel_nibble = '0;
    sel_an     = '1;
    sel_blank  = 1'b0;
    all_zero   = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero & (shadow[4*i +: 4] == 4'd0);
      if (next_idx == IW'(i)) begin
        sel_nibble = shadow[4*i +: 4];
        sel_an[i]  = 1'b0;
        sel_blank  = lz_en && (i > 0) && all_zero;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      idx   <= LAST_IDX;
    end else if (tick) begin
      count <= '0;
      idx   <= next_idx;
    end else begin
      count <= count + 1'b1;
    end
  end

  // The display stage reads shadow before this edge's load lands, so a coincident load waits a slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (load) begin
      shadow <= digits;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_BLANK;
      an  <= '1;
    end else if (tick) begin
      if (sel_blank) begin
        seg <= SEG_BLANK;
        an  <= '1;
      end else begin
        seg <= decode(sel_nibble);
        an  <= sel_an;
      end
    end
  end

endmodule
